// File: rtl/xalu_sequencer.sv
// Multi-cycle multiply/divide sequencer beside the E-stage ALU.
// Owns HI/LO, times the fixed latency and raises the D-stage stall.
module xalu_sequencer #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  XALUOp_E,
    input  logic        XALU_Src_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    input  logic        XALUUse_D,
    output logic        busy,
    output logic        start,
    output logic        stall_D,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] xalu_out_E
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    localparam logic [3:0] MULT_CNT = 4'(MULT_LAT);
    localparam logic [3:0] DIV_CNT  = 4'(DIV_LAT);

    logic [0:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;

    logic is_mult, is_multu, is_div, is_divu, is_mthi, is_mtlo;
    logic is_divide;
    logic signed [63:0] smul;
    logic [63:0]        umul;
    logic signed [31:0] sq, sr;
    logic [31:0]        uq, ur;
    logic [31:0]        res_hi, res_lo;

    assign is_mult   = (XALUOp_E == OP_MULT);
    assign is_multu  = (XALUOp_E == OP_MULTU);
    assign is_div    = (XALUOp_E == OP_DIV);
    assign is_divu   = (XALUOp_E == OP_DIVU);
    assign is_mthi   = (XALUOp_E == OP_MTHI);
    assign is_mtlo   = (XALUOp_E == OP_MTLO);
    assign is_divide = is_div | is_divu;

    assign smul = $signed({{32{rs_E[31]}}, rs_E})
                * $signed({{32{rt_E[31]}}, rt_E});
    assign umul = {32'b0, rs_E} * {32'b0, rt_E};
    assign sq   = $signed(rs_E) / $signed(rt_E);
    assign sr   = $signed(rs_E) % $signed(rt_E);
    assign uq   = rs_E / rt_E;
    assign ur   = rs_E % rt_E;

    // Zero divisor and signed overflow are resolved explicitly.
    always_comb begin
        res_hi = '0;
        res_lo = '0;
        unique case (1'b1)
            is_mult: begin
                res_hi = smul[63:32];
                res_lo = smul[31:0];
            end
            is_multu: begin
                res_hi = umul[63:32];
                res_lo = umul[31:0];
            end
            is_div: begin
                if (rt_E == 32'h0) begin
                    res_hi = rs_E;
                    res_lo = 32'hFFFF_FFFF;
                end else if (rs_E == 32'h8000_0000 &&
                             rt_E == 32'hFFFF_FFFF) begin
                    res_hi = 32'h0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = sr;
                    res_lo = sq;
                end
            end
            is_divu: begin
                if (rt_E == 32'h0) begin
                    res_hi = rs_E;
                    res_lo = 32'hFFFF_FFFF;
                end else begin
                    res_hi = ur;
                    res_lo = uq;
                end
            end
            default: ;
        endcase
    end

    assign busy       = (state_q == S_BUSY);
    assign start      = (state_q == S_IDLE) &
                        (is_mult | is_multu | is_divide);
    assign stall_D    = XALUUse_D & (busy | start);
    assign hi         = hi_q;
    assign lo         = lo_q;
    assign xalu_out_E = XALU_Src_E ? hi_q : lo_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        if (state_q == S_IDLE) begin
            if (start) begin
                pend_hi_d = res_hi;
                pend_lo_d = res_lo;
                cnt_d     = is_divide ? DIV_CNT : MULT_CNT;
                state_d   = S_BUSY;
            end else if (is_mthi) begin
                hi_d = rs_E;
            end else if (is_mtlo) begin
                lo_d = rs_E;
            end
        end else if (cnt_q > 4'd1) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            hi_d    = pend_hi_q;
            lo_d    = pend_lo_q;
            cnt_d   = '0;
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

endmodule

// File: tb/tb_xalu_sequencer.sv
// Directed self-checking bench for xalu_sequencer.
// Inputs change and outputs are sampled around the falling edge.
module tb_xalu_sequencer;

    logic        clk;
    logic        reset;
    logic [2:0]  XALUOp_E;
    logic        XALU_Src_E;
    logic [31:0] rs_E;
    logic [31:0] rt_E;
    logic        XALUUse_D;
    logic        busy;
    logic        start;
    logic        stall_D;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] xalu_out_E;

    int errors = 0;
    int checks = 0;

    xalu_sequencer #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .XALUOp_E   (XALUOp_E),
        .XALU_Src_E (XALU_Src_E),
        .rs_E       (rs_E),
        .rt_E       (rt_E),
        .XALUUse_D  (XALUUse_D),
        .busy       (busy),
        .start      (start),
        .stall_D    (stall_D),
        .hi         (hi),
        .lo         (lo),
        .xalu_out_E (xalu_out_E)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one op for one cycle, then follow it until busy drops.
    task automatic issue(input logic [2:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input logic use_d,
                         output int bc,
                         output int sc,
                         output logic st,
                         output logic held,
                         output logic post_stall);
        logic [31:0] h0, l0;
        @(negedge clk);
        XALUOp_E  = op;
        rs_E      = a;
        rt_E      = b;
        XALUUse_D = use_d;
        #1;
        st   = start;
        sc   = stall_D ? 1 : 0;
        bc   = 0;
        held = 1'b1;
        h0   = hi;
        l0   = lo;
        @(negedge clk);
        XALUOp_E = 3'b000;
        #1;
        while (busy && bc < 40) begin
            bc++;
            if (stall_D) sc++;
            if (hi !== h0 || lo !== l0) held = 1'b0;
            @(negedge clk);
            #1;
        end
        post_stall = stall_D;
        XALUUse_D  = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b0;
        #2;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset: busy=%b hi=%h lo=%h want 0/0/0",
                     busy, hi, lo);
        end
        checks++;
        if (start !== 1'b0 || stall_D !== 1'b0) begin
            errors++;
            $display("FAIL reset_start: start=%b stall=%b want 0/0",
                     start, stall_D);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mult;
        int bc, sc;
        logic st, held, ps;
        issue(3'b001, 32'hFFFF_FFFE, 32'd3, 1'b0, bc, sc, st, held, ps);
        checks++;
        if (st !== 1'b1 || bc != 5) begin
            errors++;
            $display("FAIL mult_lat: start=%b busy_cycles=%0d want 1/5",
                     st, bc);
        end
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL mult_hold: hi/lo changed during busy");
        end
        checks++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL mult: hi=%h lo=%h want ffffffff/fffffffa",
                     hi, lo);
        end
        issue(3'b010, 32'hFFFF_FFFE, 32'd3, 1'b0, bc, sc, st, held, ps);
        checks++;
        if (bc != 5 || hi !== 32'h2 || lo !== 32'hFFFF_FFFA) begin
            errors++;
            $display("FAIL multu: bc=%0d hi=%h lo=%h want 5/2/fffffffa",
                     bc, hi, lo);
        end
    endtask

    task automatic test_div;
        int bc, sc;
        logic st, held, ps;
        issue(3'b011, 32'hFFFF_FFF9, 32'd2, 1'b0, bc, sc, st, held, ps);
        checks++;
        if (bc != 10) begin
            errors++;
            $display("FAIL div_lat: busy_cycles=%0d want 10", bc);
        end
        checks++;
        if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL div: hi=%h lo=%h want ffffffff/fffffffd",
                     hi, lo);
        end
        issue(3'b100, 32'd7, 32'd2, 1'b0, bc, sc, st, held, ps);
        checks++;
        if (bc != 10 || lo !== 32'd3 || hi !== 32'd1) begin
            errors++;
            $display("FAIL divu: bc=%0d hi=%h lo=%h want 10/1/3",
                     bc, hi, lo);
        end
    endtask

    task automatic test_div_boundary;
        int bc, sc;
        logic st, held, ps;
        issue(3'b011, 32'h1234_5678, 32'h0, 1'b0, bc, sc, st, held, ps);
        checks++;
        if (lo !== 32'hFFFF_FFFF || hi !== 32'h1234_5678) begin
            errors++;
            $display("FAIL div_zero: hi=%h lo=%h want 12345678/ffffffff",
                     hi, lo);
        end
        issue(3'b100, 32'hDEAD_BEEF, 32'h0, 1'b0, bc, sc, st, held, ps);
        checks++;
        if (lo !== 32'hFFFF_FFFF || hi !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL divu_zero: hi=%h lo=%h want deadbeef/ffffffff",
                     hi, lo);
        end
        issue(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0,
              bc, sc, st, held, ps);
        checks++;
        if (lo !== 32'h8000_0000 || hi !== 32'h0) begin
            errors++;
            $display("FAIL div_ovf: hi=%h lo=%h want 0/80000000", hi, lo);
        end
    endtask

    task automatic test_stall;
        int bc, sc;
        logic st, held, ps;
        issue(3'b001, 32'd4, 32'd5, 1'b1, bc, sc, st, held, ps);
        checks++;
        if (sc != 6 || ps !== 1'b0) begin
            errors++;
            $display("FAIL stall_use: stall_cycles=%0d after=%b want 6/0",
                     sc, ps);
        end
        checks++;
        if (hi !== 32'h0 || lo !== 32'd20) begin
            errors++;
            $display("FAIL stall_mult: hi=%h lo=%h want 0/14", hi, lo);
        end
        issue(3'b001, 32'd4, 32'd5, 1'b0, bc, sc, st, held, ps);
        checks++;
        if (sc != 0 || bc != 5) begin
            errors++;
            $display("FAIL stall_nouse: stall_cycles=%0d bc=%0d want 0/5",
                     sc, bc);
        end
    endtask

    task automatic test_mthi_mtlo;
        int n;
        @(negedge clk);
        XALUOp_E = 3'b101;
        rs_E     = 32'hA5A5_A5A5;
        @(negedge clk);
        XALUOp_E = 3'b000;
        #1;
        checks++;
        if (hi !== 32'hA5A5_A5A5 || busy !== 1'b0 || lo !== 32'd20) begin
            errors++;
            $display("FAIL mthi: hi=%h lo=%h busy=%b want a5a5a5a5/14/0",
                     hi, lo, busy);
        end
        XALU_Src_E = 1'b1;
        #1;
        checks++;
        if (xalu_out_E !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL mfhi: out=%h want a5a5a5a5", xalu_out_E);
        end
        XALU_Src_E = 1'b0;
        #1;
        checks++;
        if (xalu_out_E !== 32'd20) begin
            errors++;
            $display("FAIL mflo: out=%h want 14", xalu_out_E);
        end
        @(negedge clk);
        XALUOp_E = 3'b110;
        rs_E     = 32'h0000_5A5A;
        @(negedge clk);
        XALUOp_E = 3'b000;
        #1;
        checks++;
        if (lo !== 32'h0000_5A5A || busy !== 1'b0) begin
            errors++;
            $display("FAIL mtlo: lo=%h busy=%b want 5a5a/0", lo, busy);
        end
        // MTLO arriving while a MULT is in flight must be dropped.
        @(negedge clk);
        XALUOp_E = 3'b001;
        rs_E     = 32'd5;
        rt_E     = 32'd6;
        @(negedge clk);
        XALUOp_E = 3'b110;
        rs_E     = 32'h1111_1111;
        @(negedge clk);
        XALUOp_E = 3'b000;
        #1;
        checks++;
        if (lo !== 32'h0000_5A5A || busy !== 1'b1) begin
            errors++;
            $display("FAIL mtlo_busy: lo=%h busy=%b want 5a5a/1", lo, busy);
        end
        n = 0;
        while (busy && n < 40) begin
            n++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (busy !== 1'b0 || lo !== 32'd30 || hi !== 32'h0) begin
            errors++;
            $display("FAIL mtlo_commit: busy=%b hi=%h lo=%h want 0/0/1e",
                     busy, hi, lo);
        end
    endtask

    task automatic test_reset_midbusy;
        @(negedge clk);
        XALUOp_E = 3'b101;
        rs_E     = 32'hCAFE_F00D;
        @(negedge clk);
        XALUOp_E = 3'b011;
        rs_E     = 32'd100;
        rt_E     = 32'd7;
        @(negedge clk);
        XALUOp_E = 3'b000;
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || hi !== 32'hCAFE_F00D) begin
            errors++;
            $display("FAIL pre_reset: busy=%b hi=%h want 1/cafef00d",
                     busy, hi);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_async: busy=%b hi=%h lo=%h want 0/0/0",
                     busy, hi, lo);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            errors++;
            $display("FAIL reset_nocommit: busy=%b hi=%h lo=%h want 0/0/0",
                     busy, hi, lo);
        end
    endtask

    initial begin
        XALUOp_E   = 3'b000;
        XALU_Src_E = 1'b0;
        rs_E       = 32'h0;
        rt_E       = 32'h0;
        XALUUse_D  = 1'b0;
        reset      = 1'b1;
        test_reset();
        test_mult();
        test_div();
        test_div_boundary();
        test_stall();
        test_mthi_mtlo();
        test_reset_midbusy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
